// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register carrying an instruction packet plus NUM_WORDS data
// words with a valid/ready handshake. With SKID=1 a second (skid) entry lets
// upstream ready come straight from the state register; with SKID=0 a single
// entry is held and upstream ready is combinational. Flush drops held entries,
// and a saturating counter records downstream back-pressure cycles.
module pipe_stage_buf #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_WORDS  = 3,
  parameter int PKT_WIDTH  = 32,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PKT_WIDTH-1:0]            in_pkt,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PKT_WIDTH-1:0]            out_pkt,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] out_data,
  input  logic                            flush,
  output logic [1:0]                      occupancy,
  output logic [CNT_WIDTH-1:0]            stall_cnt
);

  localparam int                   DW      = NUM_WORDS * WORD_WIDTH;
  localparam bit                   SKID_EN = (SKID != 32'sd0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PKT_WIDTH-1:0]   main_pkt_q, main_pkt_d;
  logic [DW-1:0]          main_data_q, main_data_d;
  logic [PKT_WIDTH-1:0]   skid_pkt_q, skid_pkt_d;
  logic [DW-1:0]          skid_data_q, skid_data_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic in_fire_s;
  logic out_fire_s;
  logic load_main_in_s;
  logic load_main_skid_s;
  logic load_skid_s;

  // Handshake outputs decoded from the state register (SKID=0 ready also looks at out_ready).
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    case (state_q)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
    if (SKID_EN) begin
      in_ready = (state_q != ST_FULL);
    end else begin
      in_ready = out_ready | (state_q == ST_EMPTY);
    end
    in_fire_s  = in_valid & in_ready;
    out_fire_s = out_valid & out_ready;
  end

  // Next-state and payload-move decisions; flush empties the stage and suppresses all captures.
  always_comb begin
    state_d          = state_q;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_d        = ST_ONE;
          load_main_in_s = 1'b1;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && out_fire_s) begin
          state_d        = ST_ONE;
          load_main_in_s = 1'b1;
        end else if (in_fire_s && SKID_EN) begin
          state_d     = ST_FULL;
          load_skid_s = 1'b1;
        end else if (out_fire_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_fire_s) begin
          state_d          = ST_ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d          = ST_EMPTY;
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Payload next values: registers change only when an entry is captured or promoted.
  always_comb begin
    main_pkt_d  = main_pkt_q;
    main_data_d = main_data_q;
    skid_pkt_d  = skid_pkt_q;
    skid_data_d = skid_data_q;
    if (load_main_in_s) begin
      main_pkt_d  = in_pkt;
      main_data_d = in_data;
    end else if (load_main_skid_s) begin
      main_pkt_d  = skid_pkt_q;
      main_data_d = skid_data_q;
    end else begin
      main_pkt_d  = main_pkt_q;
      main_data_d = main_data_q;
    end
    if (load_skid_s) begin
      skid_pkt_d  = in_pkt;
      skid_data_d = in_data;
    end else begin
      skid_pkt_d  = skid_pkt_q;
      skid_data_d = skid_data_q;
    end
  end

  // Back-pressure counter: counts stalled presentation cycles and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, payload and counter registers; reset clears everything and dominates flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_pkt_q  <= '0;
      main_data_q <= '0;
      skid_pkt_q  <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pkt_q  <= main_pkt_d;
      main_data_q <= main_data_d;
      skid_pkt_q  <= skid_pkt_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_pkt   = main_pkt_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance (4-bit stall counter)
// and a SKID=0 instance, driven from shared payload inputs.
module tb_pipe_stage_buf;

  localparam int WW = 16;
  localparam int NW = 3;
  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [PW-1:0] in_pkt;
  logic [NW*WW-1:0] in_data;

  logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [PW-1:0] out_pkt_a;
  logic [NW*WW-1:0] out_data_a;
  logic [1:0]    occ_a;
  logic [CW-1:0] stall_a;

  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [PW-1:0] out_pkt_b;
  logic [NW*WW-1:0] out_data_b;
  logic [1:0]    occ_b;
  logic [CW-1:0] stall_b;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .PKT_WIDTH(PW), .SKID(1), .CNT_WIDTH(CW)) u_dut_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pkt(in_pkt), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_pkt(out_pkt_a), .out_data(out_data_a), .flush(flush), .occupancy(occ_a),
    .stall_cnt(stall_a)
  );

  pipe_stage_buf #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .PKT_WIDTH(PW), .SKID(0), .CNT_WIDTH(CW)) u_dut_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pkt(in_pkt), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_pkt(out_pkt_b), .out_data(out_data_b), .flush(flush), .occupancy(occ_b),
    .stall_cnt(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW*WW-1:0] mk_data(input int k);
    logic [WW-1:0] w0, w1, w2;
    w0 = WW'(k * 16 + 1);
    w1 = WW'(k * 16 + 2);
    w2 = WW'(k * 16 + 3);
    return {w2, w1, w0};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_pkt = '0; in_data = '0;
    in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; out_ready_b = 1'b0;
    step(); step();
    reset = 1'b0;
    check_eq("rst_out_valid", 64'(out_valid_a), 64'd0);
    check_eq("rst_occ",       64'(occ_a),       64'd0);
    check_eq("rst_stall",     64'(stall_a),     64'd0);
    check_eq("rst_pkt",       64'(out_pkt_a),   64'd0);
    check_eq("rst_data",      64'(out_data_a),  64'd0);
    check_eq("rst_in_ready",  64'(in_ready_a),  64'd1);

    // Streaming at full throughput.
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    in_pkt = 32'h100; in_data = mk_data(0);
    #1;
    check_eq("stream_lat0_valid", 64'(out_valid_a), 64'd0);
    for (int k = 0; k < 5; k++) begin
      in_pkt = 32'h100 + 32'(k); in_data = mk_data(k);
      step();
      check_eq("stream_valid", 64'(out_valid_a), 64'd1);
      check_eq("stream_pkt",   64'(out_pkt_a),   64'(32'h100 + 32'(k)));
      check_eq("stream_data",  64'(out_data_a),  64'(mk_data(k)));
      check_eq("stream_occ",   64'(occ_a),       64'd1);
      check_eq("stream_rdy",   64'(in_ready_a),  64'd1);
    end
    check_eq("stream_data0_exact", 64'(mk_data(0)), 64'h0003_0002_0001);
    in_valid_a = 1'b0;
    step();
    check_eq("stream_drain_occ", 64'(occ_a), 64'd0);
    check_eq("stream_stall", 64'(stall_a), 64'd0);

    // Back-pressure fill then drain.
    out_ready_a = 1'b0; in_valid_a = 1'b1;
    in_pkt = 32'hA; in_data = mk_data(10);
    step();
    check_eq("bp_occ1", 64'(occ_a), 64'd1);
    check_eq("bp_rdy1", 64'(in_ready_a), 64'd1);
    in_pkt = 32'hB; in_data = mk_data(11);
    step();
    in_valid_a = 1'b0;
    check_eq("bp_occ2",    64'(occ_a),      64'd2);
    check_eq("bp_rdy0",    64'(in_ready_a), 64'd0);
    check_eq("bp_pkt_a",   64'(out_pkt_a),  64'hA);
    check_eq("bp_data_a",  64'(out_data_a), 64'(mk_data(10)));
    check_eq("bp_stall1",  64'(stall_a),    64'd1);
    out_ready_a = 1'b1;
    step();
    check_eq("bp_pkt_b",   64'(out_pkt_a),  64'hB);
    check_eq("bp_data_b",  64'(out_data_a), 64'(mk_data(11)));
    check_eq("bp_occ_1",   64'(occ_a),      64'd1);
    check_eq("bp_rdy_back", 64'(in_ready_a), 64'd1);
    step();
    check_eq("bp_occ_0",   64'(occ_a),      64'd0);
    check_eq("bp_valid0",  64'(out_valid_a), 64'd0);
    check_eq("bp_pkt_hold", 64'(out_pkt_a), 64'hB);

    // Flush while FULL with a pending input.
    out_ready_a = 1'b0; in_valid_a = 1'b1;
    in_pkt = 32'hA; in_data = mk_data(10);
    step();
    in_pkt = 32'hB; in_data = mk_data(11);
    step();
    check_eq("fl_occ2", 64'(occ_a), 64'd2);
    flush = 1'b1; in_pkt = 32'hC; in_data = mk_data(12);
    step();
    flush = 1'b0; in_valid_a = 1'b0;
    check_eq("fl_valid0", 64'(out_valid_a), 64'd0);
    check_eq("fl_occ0",   64'(occ_a),       64'd0);
    check_eq("fl_pkt_kept", 64'(out_pkt_a), 64'hA);
    check_eq("fl_stall",  64'(stall_a),     64'd3);
    step();
    check_eq("fl_no_c",   64'(out_valid_a), 64'd0);

    // Flush in ONE discards a simultaneous accepted input.
    in_valid_a = 1'b1; in_pkt = 32'hD; in_data = mk_data(13);
    step();
    check_eq("fl1_occ1", 64'(occ_a), 64'd1);
    flush = 1'b1; in_pkt = 32'hE; in_data = mk_data(14);
    #1;
    check_eq("fl1_rdy", 64'(in_ready_a), 64'd1);
    step();
    flush = 1'b0; in_valid_a = 1'b0;
    check_eq("fl1_occ0", 64'(occ_a), 64'd0);
    check_eq("fl1_pkt_d", 64'(out_pkt_a), 64'hD);
    check_eq("fl1_stall", 64'(stall_a), 64'd4);

    // Stall counter saturation.
    in_valid_a = 1'b1; in_pkt = 32'hF; in_data = mk_data(15);
    step();
    in_valid_a = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_15", 64'(stall_a), 64'd15);
    step();
    check_eq("sat_hold", 64'(stall_a), 64'd15);

    // Reset while FULL with a pending input.
    in_valid_a = 1'b1; in_pkt = 32'h12; in_data = mk_data(2);
    step();
    check_eq("mr_occ2", 64'(occ_a), 64'd2);
    reset = 1'b1; in_pkt = 32'h13; in_data = mk_data(3);
    step();
    reset = 1'b0; in_valid_a = 1'b0;
    check_eq("mr_valid0", 64'(out_valid_a), 64'd0);
    check_eq("mr_occ0",   64'(occ_a),       64'd0);
    check_eq("mr_stall0", 64'(stall_a),     64'd0);
    check_eq("mr_data0",  64'(out_data_a),  64'd0);
    check_eq("mr_pkt0",   64'(out_pkt_a),   64'd0);
    check_eq("mr_rdy1",   64'(in_ready_a),  64'd1);
    step();
    check_eq("mr_no_cap", 64'(out_valid_a), 64'd0);

    // SKID=0 instance: combinational ready and single-cycle replacement.
    in_valid_b = 1'b1; out_ready_b = 1'b0;
    in_pkt = 32'h21; in_data = mk_data(33);
    #1;
    check_eq("ns_rdy_empty", 64'(in_ready_b), 64'd1);
    step();
    in_pkt = 32'h22; in_data = mk_data(34);
    #1;
    check_eq("ns_rdy0",  64'(in_ready_b), 64'd0);
    check_eq("ns_occ1",  64'(occ_b),      64'd1);
    check_eq("ns_pkt1",  64'(out_pkt_b),  64'h21);
    step();
    check_eq("ns_hold",  64'(out_pkt_b),  64'h21);
    check_eq("ns_stall", 64'(stall_b),    64'd1);
    out_ready_b = 1'b1;
    #1;
    check_eq("ns_rdy_comb", 64'(in_ready_b), 64'd1);
    step();
    in_valid_b = 1'b0;
    check_eq("ns_pkt2",  64'(out_pkt_b),  64'h22);
    check_eq("ns_data2", 64'(out_data_b), 64'(mk_data(34)));
    check_eq("ns_occ_r", 64'(occ_b),      64'd1);
    check_eq("ns_valid", 64'(out_valid_b), 64'd1);
    step();
    check_eq("ns_empty", 64'(occ_b),      64'd0);
    check_eq("ns_valid0", 64'(out_valid_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
